branch_predictor: RTL

//  Fetch-side branch predictor: 2-bit saturating-counter BHT plus tagged BTB, looked up

---
 rtl/branch_predictor_if.sv | 54 +++++
 rtl/branch_predictor.sv | 124 ++++++++++++
 2 files changed

// File: rtl/branch_predictor_if.sv
// Fetch/execute-side signal bundle of the branch predictor.
// The pipeline drives the master side; the predictor implements the slave side.
interface branch_predictor_if;
    logic [31:0] pc_f;
    logic        pred_taken_f;
    logic [31:0] pred_target_f;

    logic        valid_e;
    logic        is_cti_e;
    logic [31:0] pc_e;
    logic        pred_taken_e;
    logic [31:0] pred_target_e;
    logic        br_taken_e;
    logic [31:0] target_e;

    logic        flush_o;
    logic [31:0] redirect_pc_o;
    logic [31:0] cti_cnt_o;
    logic [31:0] mispred_cnt_o;

    modport master (
        output pc_f,
        output valid_e,
        output is_cti_e,
        output pc_e,
        output pred_taken_e,
        output pred_target_e,
        output br_taken_e,
        output target_e,
        input  pred_taken_f,
        input  pred_target_f,
        input  flush_o,
        input  redirect_pc_o,
        input  cti_cnt_o,
        input  mispred_cnt_o
    );

    modport slave (
        input  pc_f,
        input  valid_e,
        input  is_cti_e,
        input  pc_e,
        input  pred_taken_e,
        input  pred_target_e,
        input  br_taken_e,
        input  target_e,
        output pred_taken_f,
        output pred_target_f,
        output flush_o,
        output redirect_pc_o,
        output cti_cnt_o,
        output mispred_cnt_o
    );
endinterface

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: 2-bit saturating-counter BHT with a tagged BTB,
// trained from execute-stage resolution, raising flush/redirect on mispredict.
module branch_predictor #(
    parameter  int ENTRIES = 16,
    localparam int IDX_W   = $clog2(ENTRIES),
    localparam int TAG_W   = 30 - IDX_W
) (
    input logic               clk,
    input logic               rst_n,
    branch_predictor_if.slave bp
);

    logic             valid_q [ENTRIES];
    logic [1:0]       ctr_q   [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [31:0]      tgt_q   [ENTRIES];

    logic [IDX_W-1:0] idx_f;
    logic [TAG_W-1:0] tag_f;
    logic             hit_f;

    logic [IDX_W-1:0] idx_e;
    logic [TAG_W-1:0] tag_e;
    logic             hit_e;
    logic             cti_vld_e;
    logic             mis_e;
    logic             flush;
    logic [31:0]      next_pc_e;

    logic [31:0]      cti_cnt_q;
    logic [31:0]      mispred_cnt_q;

    logic             unused_lsbs;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    // PCs are word aligned; the low two bits never select anything.
    assign unused_lsbs = ^{bp.pc_f[1:0], bp.pc_e[1:0]};

    // ---- fetch lookup: reads the registered table, no bypass from the update port
    assign idx_f = bp.pc_f[IDX_W+1:2];
    assign tag_f = bp.pc_f[31:IDX_W+2];
    assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);

    assign bp.pred_taken_f  = rst_n & hit_f & ctr_q[idx_f][1];
    assign bp.pred_target_f = hit_f ? tgt_q[idx_f] : 32'h0;

    // ---- execute resolution
    assign idx_e     = bp.pc_e[IDX_W+1:2];
    assign tag_e     = bp.pc_e[31:IDX_W+2];
    assign hit_e     = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    assign cti_vld_e = bp.valid_e & bp.is_cti_e;

    always_comb begin
        mis_e = 1'b0;
        if (bp.is_cti_e) begin
            mis_e = (bp.pred_taken_e != bp.br_taken_e) ||
                    (bp.br_taken_e && (bp.pred_target_e != bp.target_e));
        end else begin
            // A predicted-taken non-CTI means fetch was steered by an aliasing entry.
            mis_e = bp.pred_taken_e;
        end
    end

    assign next_pc_e = (bp.br_taken_e && bp.is_cti_e) ? bp.target_e : bp.pc_e + 32'd4;
    assign flush     = rst_n & bp.valid_e & mis_e;

    assign bp.flush_o       = flush;
    assign bp.redirect_pc_o = flush ? next_pc_e : 32'h0;

    // ---- table update, one edge after resolution; reset takes priority
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
                tag_q[i]   <= '0;
                tgt_q[i]   <= 32'h0;
            end
        end else if (bp.valid_e) begin
            if (bp.is_cti_e) begin
                if (hit_e) begin
                    ctr_q[idx_e] <= bp.br_taken_e ? sat_inc(ctr_q[idx_e]) : sat_dec(ctr_q[idx_e]);
                    if (bp.br_taken_e) begin
                        tgt_q[idx_e] <= bp.target_e;
                    end
                end else if (bp.br_taken_e) begin
                    // Allocate weakly taken so one not-taken outcome flips the prediction.
                    valid_q[idx_e] <= 1'b1;
                    tag_q[idx_e]   <= tag_e;
                    tgt_q[idx_e]   <= bp.target_e;
                    ctr_q[idx_e]   <= 2'b10;
                end
            end else if (hit_e) begin
                valid_q[idx_e] <= 1'b0;
            end
        end
    end

    // ---- statistics counters, free-running with natural 32-bit wrap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cti_cnt_q     <= 32'h0;
            mispred_cnt_q <= 32'h0;
        end else begin
            if (cti_vld_e) begin
                cti_cnt_q <= cti_cnt_q + 32'd1;
            end
            if (flush) begin
                mispred_cnt_q <= mispred_cnt_q + 32'd1;
            end
        end
    end

    assign bp.cti_cnt_o     = cti_cnt_q;
    assign bp.mispred_cnt_o = mispred_cnt_q;

endmodule
